// File: rtl/wave_disp.sv
// wave_disp: oscilloscope pixel source. Captures ADC samples into a double-buffered
// sample RAM and renders a graticule plus a connected trace as 24-bit RGB.
module wave_disp #(
    parameter int          H_PIX   = 800,
    parameter int          GRID    = 50,
    parameter int          Y_OFS   = 172,
    parameter int          AUTO_TO = 4095,
    parameter logic [23:0] C_TRACE = 24'hFFFF00,
    parameter logic [23:0] C_GRID  = 24'h404040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        smp_valid,
    input  logic [7:0]  smp_data,
    input  logic        trig_en,
    input  logic [7:0]  trig_level,
    input  logic [10:0] value_x,
    input  logic [10:0] value_y,
    input  logic        vga_vs,
    output logic [23:0] rgb,
    output logic        cap_busy,
    output logic        swap_pulse
);
    localparam int              TW        = $clog2(AUTO_TO + 1);
    localparam int              GW        = $clog2(GRID);
    localparam logic [TW-1:0]   TMO_MAX   = TW'(AUTO_TO);
    localparam logic [9:0]      LAST_ADDR = 10'(H_PIX - 1);
    localparam logic [10:0]     X_END     = 11'(H_PIX);
    localparam logic [10:0]     Y_BASE    = 11'(Y_OFS + 255);
    localparam logic [GW-1:0]   G_LAST    = GW'(GRID - 1);

    typedef enum logic [1:0] {
        WAIT_TRIG = 2'd0,
        CAPTURE   = 2'd1,
        FULL      = 2'd2
    } state_t;

    state_t          r_state;
    logic [9:0]      r_wr_addr;
    logic            r_disp_bank;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_prev_smp;
    logic            r_vs_d;
    logic            r_cap_busy;
    logic            r_swap;

    logic            w_fall;
    logic            w_trig;
    logic            w_we;
    logic [9:0]      w_waddr;

    assign w_fall  = r_vs_d & ~vga_vs;
    assign w_trig  = !trig_en
                   || ((r_prev_smp < trig_level) && (trig_level <= smp_data))
                   || (r_tmo == TMO_MAX);
    assign w_we    = smp_valid && (((r_state == WAIT_TRIG) && w_trig) || (r_state == CAPTURE));
    assign w_waddr = (r_state == WAIT_TRIG) ? 10'd0 : r_wr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_TRIG;
            r_wr_addr   <= 10'd0;
            r_disp_bank <= 1'b0;
            r_tmo       <= '0;
            r_prev_smp  <= 8'd0;
            r_vs_d      <= 1'b0;
            r_cap_busy  <= 1'b0;
            r_swap      <= 1'b0;
        end else begin
            r_vs_d     <= vga_vs;
            r_swap     <= 1'b0;
            r_cap_busy <= 1'b1;
            case (r_state)
                WAIT_TRIG: begin
                    if (smp_valid) begin
                        r_prev_smp <= smp_data;
                        if (w_trig) begin
                            r_state   <= CAPTURE;
                            r_wr_addr <= 10'd1;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (smp_valid) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (r_wr_addr == LAST_ADDR) begin
                            r_state    <= FULL;
                            r_cap_busy <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    r_cap_busy <= 1'b0;
                    // Swap only on a frame boundary so no frame mixes two captures.
                    if (w_fall) begin
                        r_disp_bank <= ~r_disp_bank;
                        r_swap      <= 1'b1;
                        r_wr_addr   <= 10'd0;
                        r_tmo       <= '0;
                        r_state     <= WAIT_TRIG;
                        r_cap_busy  <= 1'b1;
                    end
                end
                default: r_state <= WAIT_TRIG;
            endcase
        end
    end

    assign cap_busy   = r_cap_busy;
    assign swap_pulse = r_swap;

    // Two banks of 1024 bytes; the bank bit is the address MSB.
    logic [7:0] r_mem [0:2047];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{~r_disp_bank, w_waddr}] <= smp_data;
        end
        r_rd_data <= r_mem[{r_disp_bank, value_x[9:0]}];
    end

    logic [GW-1:0] r_gx;
    logic [GW-1:0] r_gy;
    logic          r_vy_nz;
    logic [GW-1:0] w_gx;
    logic [GW-1:0] w_gy;
    logic          w_vy_rise;
    logic          w_act0;

    assign w_act0    = (value_x != 11'd0) && (value_y != 11'd0) && (value_x < X_END);
    assign w_gx      = (value_x == 11'd0) ? '0 : ((r_gx == G_LAST) ? '0 : r_gx + 1'b1);
    assign w_vy_rise = (value_y != 11'd0) && !r_vy_nz;
    assign w_gy      = !vga_vs ? '0
                     : (w_vy_rise ? ((r_gy == G_LAST) ? '0 : r_gy + 1'b1) : r_gy);

    logic [10:0] r_y1;
    logic        r_act1;
    logic        r_first1;
    logic        r_grid1;
    logic [7:0]  r_prev_s;
    logic [23:0] r_rgb;

    logic [7:0]  w_p;
    logic [10:0] w_rs;
    logic [10:0] w_rp;
    logic [10:0] w_lo;
    logic [10:0] w_hi;

    assign w_p  = r_first1 ? r_rd_data : r_prev_s;
    assign w_rs = Y_BASE - {3'b000, r_rd_data};
    assign w_rp = Y_BASE - {3'b000, w_p};
    assign w_lo = (w_rs < w_rp) ? w_rs : w_rp;
    assign w_hi = (w_rs < w_rp) ? w_rp : w_rs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx     <= '0;
            r_gy     <= '0;
            r_vy_nz  <= 1'b0;
            r_y1     <= 11'd0;
            r_act1   <= 1'b0;
            r_first1 <= 1'b0;
            r_grid1  <= 1'b0;
            r_prev_s <= 8'd0;
            r_rgb    <= 24'd0;
        end else begin
            r_gx     <= w_gx;
            r_gy     <= w_gy;
            r_vy_nz  <= (value_y != 11'd0);
            r_y1     <= value_y;
            r_act1   <= w_act0;
            r_first1 <= (value_x == 11'd1);
            r_grid1  <= (w_gx == '0) || (w_gy == '0);
            // Holds the sample of the column just rendered: the left end of the segment.
            r_prev_s <= r_rd_data;
            if (!r_act1) begin
                r_rgb <= 24'd0;
            end else if ((r_y1 >= w_lo) && (r_y1 <= w_hi)) begin
                r_rgb <= C_TRACE;
            end else if (r_grid1) begin
                r_rgb <= C_GRID;
            end else begin
                r_rgb <= 24'd0;
            end
        end
    end

    assign rgb = r_rgb;

endmodule
